// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output decimator.
package fir_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic {ST_WARMUP, ST_RUN} dec_state_t;

    typedef logic [DEF_WIDTH-1:0] sample_t;

    // Bits needed to count 0..n-1; a zero-width counter is never wanted.
    function automatic int bits_for(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// FIR output bus into the decimator, plus its valid/ready drain side and status.
interface fir_decimator_if
    import fir_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_en;
    logic [WIDTH-1:0] Yn;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             overflow;

    modport master (
        output in_en, Yn, out_ready,
        input  out_data, out_valid, count, overflow
    );

    modport slave (
        input  in_en, Yn, out_ready,
        output out_data, out_valid, count, overflow
    );

endinterface

// File: rtl/fir_decimator_sync_fifo.sv
// First-word-fall-through FIFO with an explicit fill count so full and empty never alias.
module sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A pop on an empty FIFO is ignored; a pop frees the slot a full-FIFO push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fir_decimator.sv
// Drops the FIR start-up transient, keeps one of every DECIM samples and buffers them
// for a valid/ready consumer.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DECIM  = 4,
    parameter int WARMUP = 3,
    parameter int DEPTH  = 8
) (
    input logic            clk,
    input logic            rst,
    fir_decimator_if.slave bus
);
    localparam int WW = bits_for(WARMUP + 1);
    localparam int PW = bits_for(DECIM);
    localparam int CW = $clog2(DEPTH + 1);

    dec_state_t       state;
    logic [WW-1:0]    warm_cnt;
    logic [PW-1:0]    phase;
    logic             overflow;
    logic             keep;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    fill;

    assign keep = bus.in_en && (state == ST_RUN) && (phase == '0);
    assign pop  = !empty && bus.out_ready;
    assign drop = keep && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            warm_cnt <= '0;
            phase    <= '0;
            overflow <= 1'b0;
        end else begin
            if (bus.in_en) begin
                case (state)
                    ST_WARMUP: begin
                        // The sample that completes warm-up is itself still discarded.
                        if (warm_cnt == WW'(WARMUP - 1)) state <= ST_RUN;
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                    ST_RUN: begin
                        phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
                    end
                    default: state <= ST_WARMUP;
                endcase
            end
            if (drop) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (keep),
        .pop     (pop),
        .wr_data (bus.Yn),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fill)
    );

    assign bus.out_data  = head;
    assign bus.out_valid = !empty;
    assign bus.count     = fill;
    assign bus.overflow  = overflow;

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of the FIR filter: consumes the filtered output `Yn` and discards the filter's start-up transient. It decimates the sample stream by an integer factor and buffers kept samples in a small FIFO. The FIFO drains through a valid/ready handshake to the next consumer, such as a serializer or DMA. Sits directly on the FIR output bus, in the same clock domain.

## Interface
- `WIDTH`, 16: sample width; must match the FIR `WIDTH`.
- `DECIM`, 4: decimation factor M ≥ 1; one of every M post-warm-up samples is kept.
- `WARMUP`, 3: number of leading samples discarded after reset; equals FIR tap count N−1.
- `DEPTH`, 8: FIFO depth; power of two, ≥ 2.
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_en`, in, 1: `Yn` holds a new sample this cycle. Tie high when the FIR shifts every clock.
- `Yn`, in, `WIDTH`: filtered sample from the FIR.
- `out_data`, out, `WIDTH`: FIFO head sample.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: consumer accepts the head when `out_valid` is also high.
- `count`, out, `$clog2(DEPTH+1)`: current FIFO fill level.
- `overflow`, out, 1: sticky flag; a kept sample was dropped.

## Operation
- **States** (`ST_WARMUP`, `ST_RUN`):
  - Reset state is `ST_WARMUP`, or `ST_RUN` if `WARMUP`=0.
  - In `ST_WARMUP`, `warm_cnt` increments on each `in_en`; samples are discarded.
  - Transition to `ST_RUN` occurs on the `in_en` that brings `warm_cnt` to `WARMUP`; that sample is also discarded.
- **Phase counter**, range 0..`DECIM`−1:
  - Active only in `ST_RUN`; advances only on `in_en` and wraps from `DECIM`−1 to 0.
  - A sample is kept when `in_en`=1 and phase=0, so the first post-warm-up sample is kept.
  - `DECIM`=1 keeps every sample.
- **Push**: occurs on a kept sample when the FIFO is not full, or when it is full and a pop happens in the same cycle.
- **Pop**: occurs when `out_valid` && `out_ready`.
- **Full with no pop**: the kept sample is dropped, `overflow` is set to 1, and FIFO contents are unchanged. `overflow` clears only on `rst`.
- **Empty**:
  - `out_valid`=0; `out_ready` is ignored.
  - `out_data` is don't-care; it shows the memory at the read pointer.
- **Simultaneous push and pop** (any fill level, including full): `count` is unchanged.
  - Exception: when empty, only the push takes effect.
- **Pointers**: `log2(DEPTH)`-bit, natural wrap. `count` is tracked separately, so full (`count`=`DEPTH`) and empty (`count`=0) are unambiguous.
- **Data path**: no arithmetic on data; samples pass through bit-exact.
- **Reset mid-operation**: at the next edge the FIFO is flushed, counters and phase are zeroed, and the state returns to warm-up. In-flight data is lost.

## Timing
- **Reset values**: `out_valid`=0, `count`=0, `overflow`=0. `out_data` is don't-care while `out_valid`=0.
- **Latency**: a kept sample captured at edge k appears at the head, with `out_valid`=1, after edge k when the FIFO was empty. One-cycle latency.
- **`count`**: reflects the push/pop of edge k immediately after edge k.
- **`out_data`**: first-word-fall-through; combinational read of the register array at the read pointer.
- **`out_valid`**: decoded from `count`≠0; no combinational path from `out_ready`.
- **Handshake**: `out_data` and `out_valid` stay stable while `out_valid`=1 and `out_ready`=0.
- **Throughput**: one push and one pop per cycle, sustained.

## Structure
- **Package `fir_pkg`**:
  - `WIDTH` default constant.
  - `typedef enum logic {ST_WARMUP, ST_RUN} dec_state_t`.
  - Sample type `typedef logic [WIDTH-1:0] sample_t`.
- **Sub-module `sync_fifo`**: parameterised by `WIDTH` and `DEPTH`, with push, pop, full, empty and `count`.
- **Top level**: holds the state machine, warm-up counter, phase counter, keep/drop decision and overflow flag.

## Test plan
1. **Reset values**: hold `rst`=1 for 3 cycles with `in_en`=1 and arbitrary `Yn` → `out_valid`=0, `count`=0, `overflow`=0 throughout.
2. **Warm-up and decimation**: defaults, `in_en`=1, `Yn`=0,1,2,… from the first post-reset cycle, `out_ready`=1 → outputs 3,7,11,15 in order, each with `out_valid` for exactly one cycle.
3. **Overflow**: `DECIM`=1, `WARMUP`=0, `DEPTH`=8, `out_ready`=0, `Yn`=100..109 → `count` saturates at 8 and `overflow` rises at sample 108. Then `out_ready`=1 drains exactly 100..107.
4. **Full with simultaneous pop**: FIFO full (`count`=8), `out_ready`=1, kept sample 200 → `count` stays 8, `overflow` stays 0, and 200 is the last value drained.
5. **Input gaps**: `in_en` pattern 1,0,1,0… with `Yn` incrementing every cycle, defaults → only `in_en` cycles count. Outputs are the 4th, 8th, 12th… enabled samples.
6. **Reset mid-stream**: `rst` pulsed for 1 cycle with `count`=5 → next cycle `count`=0, `out_valid`=0. The following 3 samples are discarded, and the 4th is output first.
